// File: rtl/fir_coeff_loader_if.sv
// Coefficient stream, swap strobe and status bundle between a host and fir_coeff_loader.
// The host drives through the master modport; the loader sits on the slave modport.
interface fir_coeff_loader_if #(
  parameter int NTAPS = 33,
  parameter int CW    = 16,
  parameter int IDX_W = 6
);
  logic                  cfg_valid;
  logic                  cfg_ready;
  logic [CW-1:0]         cfg_data;
  logic                  cfg_last;
  logic                  cfg_abort;
  logic                  swap_en;
  logic [NTAPS*CW-1:0]   coeff_flat;
  logic                  busy;
  logic                  load_done;
  logic                  load_err;
  logic                  bank_id;
  logic [IDX_W-1:0]      wr_count;

  modport master (
    output cfg_valid, cfg_data, cfg_last, cfg_abort, swap_en,
    input  cfg_ready, coeff_flat, busy, load_done, load_err, bank_id, wr_count
  );

  modport slave (
    input  cfg_valid, cfg_data, cfg_last, cfg_abort, swap_en,
    output cfg_ready, coeff_flat, busy, load_done, load_err, bank_id, wr_count
  );
endinterface

// File: rtl/fir_coeff_loader.sv
// Double-buffered coefficient loader for the 33-tap FIR: words fill a shadow bank and the
// whole set is copied to the active bank in one cycle on a sample-boundary swap strobe.
module fir_coeff_loader #(
  parameter int NTAPS = 33,
  parameter int CW    = 16,
  parameter int IDX_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  fir_coeff_loader_if.slave bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_PEND} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NTAPS - 1);

  state_t              r_state;
  logic [IDX_W-1:0]    r_wr_count;
  logic [CW-1:0]       r_shadow [NTAPS];
  logic [NTAPS*CW-1:0] r_coeff;
  logic                r_bank_id;
  logic                r_load_done;
  logic                r_load_err;
  logic                r_busy;

  logic                w_ready;
  logic                w_xfer;

  // Abort wins over a simultaneous transfer, so the word is never written.
  assign w_ready = (r_state != ST_PEND);
  assign w_xfer  = bus.cfg_valid && w_ready && !bus.cfg_abort;

  // Shadow bank holds only data; its contents are irrelevant until a full set lands.
  always_ff @(posedge clk) begin
    if (w_xfer) begin
      r_shadow[r_wr_count] <= bus.cfg_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_wr_count  <= '0;
      r_coeff     <= '0;
      r_bank_id   <= 1'b0;
      r_load_done <= 1'b0;
      r_load_err  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_load_done <= 1'b0;
      r_load_err  <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_xfer) begin
            if (bus.cfg_last) begin
              r_load_err <= 1'b1;
            end else begin
              r_state    <= ST_LOAD;
              r_wr_count <= IDX_W'(1);
              r_busy     <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (bus.cfg_abort) begin
            r_state    <= ST_IDLE;
            r_wr_count <= '0;
            r_busy     <= 1'b0;
          end else if (w_xfer) begin
            if ((r_wr_count == LAST_IDX) && bus.cfg_last) begin
              r_state <= ST_PEND;
            end else if ((r_wr_count == LAST_IDX) || bus.cfg_last) begin
              r_load_err <= 1'b1;
              r_state    <= ST_IDLE;
              r_wr_count <= '0;
              r_busy     <= 1'b0;
            end else begin
              r_wr_count <= r_wr_count + IDX_W'(1);
            end
          end
        end
        ST_PEND: begin
          if (bus.cfg_abort) begin
            r_state    <= ST_IDLE;
            r_wr_count <= '0;
            r_busy     <= 1'b0;
          end else if (bus.swap_en) begin
            for (int k = 0; k < NTAPS; k++) begin
              r_coeff[k*CW +: CW] <= r_shadow[k];
            end
            r_bank_id   <= ~r_bank_id;
            r_load_done <= 1'b1;
            r_state     <= ST_IDLE;
            r_wr_count  <= '0;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_wr_count <= '0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cfg_ready  = w_ready;
  assign bus.coeff_flat = r_coeff;
  assign bus.busy       = r_busy;
  assign bus.load_done  = r_load_done;
  assign bus.load_err   = r_load_err;
  assign bus.bank_id    = r_bank_id;
  assign bus.wr_count   = r_wr_count;

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Scoreboard bench for fir_coeff_loader: each complete set is queued when its swap is issued
// and popped against coeff_flat when load_done appears.
module tb_fir_coeff_loader;
  localparam int NTAPS = 33;
  localparam int CW    = 16;
  localparam int IDX_W = 6;
  localparam int FW    = NTAPS * CW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  int n_done = 0;
  int n_err = 0;
  logic [FW-1:0] q_exp[$];
  logic [FW-1:0] exp_active = '0;
  logic exp_bank = 1'b0;

  fir_coeff_loader_if #(.NTAPS(NTAPS), .CW(CW), .IDX_W(IDX_W)) ifc ();

  fir_coeff_loader #(.NTAPS(NTAPS), .CW(CW), .IDX_W(IDX_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ifc.load_done === 1'b1) n_done++;
    if (ifc.load_err === 1'b1) n_err++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [CW-1:0] d, input logic last, input int gap_pct);
    int guard;
    logic rdy;
    while (int'($urandom_range(99, 0)) < gap_pct) begin
      ifc.cfg_valid = 1'b0;
      ifc.cfg_data  = CW'($urandom);
      step();
    end
    ifc.cfg_valid = 1'b1;
    ifc.cfg_data  = d;
    ifc.cfg_last  = last;
    guard = 0;
    do begin
      rdy = ifc.cfg_ready;
      step();
      guard++;
    end while (!rdy && guard < 20);
    if (!rdy) begin
      checks++; failures++;
      $display("FAIL send_word_timeout ready=%b required=1", rdy);
    end
    ifc.cfg_valid = 1'b0;
    ifc.cfg_last  = 1'b0;
    ifc.cfg_data  = CW'($urandom);
  endtask

  task automatic send_words(input logic [FW-1:0] set, input int n, input logic last_on_n,
                            input int gap_pct);
    for (int k = 0; k < n; k++)
      send_word(set[k*CW +: CW], (k == n - 1) ? last_on_n : 1'b0, gap_pct);
  endtask

  task automatic rand_set(output logic [FW-1:0] set);
    for (int k = 0; k < NTAPS; k++) set[k*CW +: CW] = CW'($urandom);
  endtask

  task automatic swap_and_check(input string name, input logic [FW-1:0] set);
    int guard;
    int d0;
    q_exp.push_back(set);
    d0 = n_done;
    ifc.swap_en = 1'b1;
    step();
    ifc.swap_en = 1'b0;
    guard = 0;
    while (ifc.load_done !== 1'b1 && guard < 10) begin step(); guard++; end
    checks++;
    if (guard != 0) begin
      failures++;
      $display("FAIL %s_done_latency got=%0d extra cycles required=0", name, guard);
    end
    exp_active = q_exp.pop_front();
    exp_bank   = ~exp_bank;
    checks++;
    if (ifc.coeff_flat !== exp_active) begin
      failures++;
      $display("FAIL %s_coeff got=%h required=%h", name, ifc.coeff_flat, exp_active);
    end
    checks++;
    if (ifc.bank_id !== exp_bank) begin
      failures++; $display("FAIL %s_bank got=%b required=%b", name, ifc.bank_id, exp_bank);
    end
    checks++;
    if (ifc.busy !== 1'b0) begin
      failures++; $display("FAIL %s_busy got=%b required=0", name, ifc.busy);
    end
    step();
    checks++;
    if (ifc.load_done !== 1'b0) begin
      failures++; $display("FAIL %s_done_width got=%b required=0", name, ifc.load_done);
    end
    step();
    checks++;
    if (n_done - d0 != 1) begin
      failures++; $display("FAIL %s_done_pulses got=%0d required=1", name, n_done - d0);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    checks++;
    if (ifc.coeff_flat !== '0 || ifc.bank_id !== 1'b0 || ifc.busy !== 1'b0 ||
        ifc.load_done !== 1'b0 || ifc.load_err !== 1'b0 || ifc.wr_count !== '0) begin
      failures++;
      $display("FAIL reset_values got coeff=%h bank=%b busy=%b done=%b err=%b cnt=%0d required all 0",
               ifc.coeff_flat, ifc.bank_id, ifc.busy, ifc.load_done, ifc.load_err, ifc.wr_count);
    end
    rst_n = 1'b1;
    checks++;
    if (ifc.cfg_ready !== 1'b1) begin
      failures++; $display("FAIL reset_ready got=%b required=1", ifc.cfg_ready);
    end
  endtask

  task automatic test_full_load();
    logic [FW-1:0] set;
    for (int k = 0; k < NTAPS; k++) set[k*CW +: CW] = CW'(k + 1);
    send_words(set, NTAPS, 1'b1, 0);
    checks++;
    if (ifc.busy !== 1'b1 || ifc.cfg_ready !== 1'b0) begin
      failures++;
      $display("FAIL pend_state got busy=%b ready=%b required busy=1 ready=0", ifc.busy, ifc.cfg_ready);
    end
    step();
    step();
    checks++;
    if (ifc.cfg_ready !== 1'b0 || ifc.coeff_flat !== '0) begin
      failures++;
      $display("FAIL pend_hold got ready=%b coeff=%h required ready=0 coeff=0", ifc.cfg_ready, ifc.coeff_flat);
    end
    swap_and_check("full", set);
  endtask

  task automatic test_early_last();
    logic [FW-1:0] set;
    int e0, d0;
    rand_set(set);
    e0 = n_err;
    d0 = n_done;
    send_words(set, 10, 1'b1, 0);
    checks++;
    if (ifc.load_err !== 1'b1 || ifc.wr_count !== '0 || ifc.busy !== 1'b0) begin
      failures++;
      $display("FAIL early_last got err=%b cnt=%0d busy=%b required err=1 cnt=0 busy=0",
               ifc.load_err, ifc.wr_count, ifc.busy);
    end
    ifc.swap_en = 1'b1;
    step();
    ifc.swap_en = 1'b0;
    step();
    checks++;
    if (n_err - e0 != 1 || n_done != d0) begin
      failures++;
      $display("FAIL early_last_pulses got err=%0d done=%0d required err=1 done=0", n_err - e0, n_done - d0);
    end
    checks++;
    if (ifc.coeff_flat !== exp_active || ifc.bank_id !== exp_bank) begin
      failures++;
      $display("FAIL early_last_bank got coeff=%h bank=%b required coeff=%h bank=%b",
               ifc.coeff_flat, ifc.bank_id, exp_active, exp_bank);
    end
    rand_set(set);
    send_words(set, NTAPS, 1'b1, 0);
    swap_and_check("reload", set);
  endtask

  task automatic test_late_last();
    logic [FW-1:0] set;
    int e0;
    rand_set(set);
    e0 = n_err;
    send_words(set, NTAPS, 1'b0, 0);
    checks++;
    if (ifc.load_err !== 1'b1 || ifc.busy !== 1'b0 || ifc.cfg_ready !== 1'b1 || ifc.wr_count !== '0) begin
      failures++;
      $display("FAIL late_last got err=%b busy=%b ready=%b cnt=%0d required err=1 busy=0 ready=1 cnt=0",
               ifc.load_err, ifc.busy, ifc.cfg_ready, ifc.wr_count);
    end
    step();
    checks++;
    if (ifc.coeff_flat !== exp_active || ifc.bank_id !== exp_bank || n_err - e0 != 1) begin
      failures++;
      $display("FAIL late_last_bank got bank=%b errs=%0d required bank=%b errs=1",
               ifc.bank_id, n_err - e0, exp_bank);
    end
  endtask

  task automatic test_gaps();
    logic [FW-1:0] set;
    for (int k = 0; k < NTAPS; k++) set[k*CW +: CW] = 16'h8000;
    send_words(set, NTAPS, 1'b1, 50);
    swap_and_check("gap8000", set);
    for (int k = 0; k < NTAPS; k++) set[k*CW +: CW] = CW'(16'h8000 ^ (k * 16'h0101));
    send_words(set, NTAPS, 1'b1, 50);
    swap_and_check("gapseq", set);
  endtask

  task automatic test_abort();
    logic [FW-1:0] set;
    int d0, e0;
    rand_set(set);
    send_words(set, NTAPS, 1'b1, 0);
    d0 = n_done;
    e0 = n_err;
    ifc.cfg_abort = 1'b1;
    ifc.swap_en   = 1'b1;
    step();
    ifc.cfg_abort = 1'b0;
    ifc.swap_en   = 1'b0;
    checks++;
    if (ifc.busy !== 1'b0 || ifc.cfg_ready !== 1'b1 || ifc.wr_count !== '0 || ifc.load_done !== 1'b0) begin
      failures++;
      $display("FAIL abort_pend got busy=%b ready=%b cnt=%0d done=%b required 0 1 0 0",
               ifc.busy, ifc.cfg_ready, ifc.wr_count, ifc.load_done);
    end
    step();
    step();
    checks++;
    if (n_done != d0 || n_err != e0 || ifc.coeff_flat !== exp_active || ifc.bank_id !== exp_bank) begin
      failures++;
      $display("FAIL abort_pend_bank got done=%0d err=%0d bank=%b required done=0 err=0 bank=%b",
               n_done - d0, n_err - e0, ifc.bank_id, exp_bank);
    end
    send_words(set, 5, 1'b0, 0);
    ifc.cfg_abort = 1'b1;
    ifc.cfg_valid = 1'b1;
    ifc.cfg_data  = 16'hDEAD;
    step();
    ifc.cfg_abort = 1'b0;
    ifc.cfg_valid = 1'b0;
    checks++;
    if (ifc.wr_count !== '0 || ifc.busy !== 1'b0 || n_err != e0) begin
      failures++;
      $display("FAIL abort_load got cnt=%0d busy=%b errs=%0d required 0 0 0", ifc.wr_count, ifc.busy, n_err - e0);
    end
  endtask

  task automatic test_reset_midload();
    logic [FW-1:0] set;
    rand_set(set);
    send_words(set, 20, 1'b0, 0);
    checks++;
    if (ifc.wr_count !== IDX_W'(20)) begin
      failures++; $display("FAIL midload_count got=%0d required=20", ifc.wr_count);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    exp_active = '0;
    exp_bank   = 1'b0;
    checks++;
    if (ifc.coeff_flat !== '0 || ifc.wr_count !== '0 || ifc.bank_id !== 1'b0 ||
        ifc.busy !== 1'b0 || ifc.cfg_ready !== 1'b1) begin
      failures++;
      $display("FAIL midload_reset got coeff=%h cnt=%0d bank=%b busy=%b ready=%b required 0 0 0 0 1",
               ifc.coeff_flat, ifc.wr_count, ifc.bank_id, ifc.busy, ifc.cfg_ready);
    end
    rand_set(set);
    send_words(set, NTAPS, 1'b1, 0);
    swap_and_check("post_reset", set);
  endtask

  initial begin
    ifc.cfg_valid = 1'b0;
    ifc.cfg_data  = '0;
    ifc.cfg_last  = 1'b0;
    ifc.cfg_abort = 1'b0;
    ifc.swap_en   = 1'b0;
    test_reset();
    test_full_load();
    test_early_last();
    test_late_last();
    test_gaps();
    test_abort();
    test_reset_midload();
    checks++;
    if (q_exp.size() != 0) begin
      failures++; $display("FAIL scoreboard_left got=%0d required=0", q_exp.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fir_coeff_loader.md
Name: fir_coeff_loader

Overview:
- Upstream configuration stage for the 33-tap FIR core; drives its coeff_00..coeff_32 inputs.
- Accepts coefficients as a valid/ready word stream into a shadow bank.
- Once the set is complete and terminated, applies all 33 coefficients to the active bank at once, on a sample-boundary strobe, so the FIR never sees a partially updated coefficient set.

Parameters:
- NTAPS, 33, number of coefficients per set.
- CW, 16, coefficient width in bits (two's complement, passed through unmodified).
- IDX_W, 6, width of the word counter; must satisfy 2^IDX_W > NTAPS.

Ports:
- clk  input  1  single clock; all logic is in this domain.
- rst_n  input  1  reset; synchronous, active-low.
- cfg_valid  input  1  cfg_data/cfg_last are valid this cycle.
- cfg_ready  output  1  loader accepts a word this cycle.
- cfg_data  input  CW  coefficient word; the first word of a set is tap 0.
- cfg_last  input  1  marks the final word of a set.
- cfg_abort  input  1  discards the load in progress.
- swap_en  input  1  sample-boundary strobe; allows the shadow-to-active copy.
- coeff_flat  output  NTAPS*CW  active coefficients; tap k is at bits [k*CW+CW-1 : k*CW].
- busy  output  1  high in LOAD or PEND.
- load_done  output  1  one-cycle pulse when the active bank updates.
- load_err  output  1  one-cycle pulse on a framing error.
- bank_id  output  1  toggles on every successful swap.
- wr_count  output  IDX_W  words accepted in the current set.

Behaviour:
- Handshake:
  - A word transfers when cfg_valid and cfg_ready are both high on a rising clk.
  - cfg_ready = 1 in IDLE and LOAD; cfg_ready = 0 in PEND.
  - cfg_data is ignored when no transfer occurs.
- States:
  - IDLE: wr_count = 0. A transfer writes shadow[0]. With cfg_last = 0 -> LOAD, wr_count = 1. With cfg_last = 1 -> framing error.
  - LOAD: a transfer writes shadow[wr_count] and increments wr_count.
  - Framing rules in LOAD:
    - Transfer with wr_count = NTAPS-1 and cfg_last = 1 -> PEND.
    - Transfer with cfg_last = 1 and wr_count < NTAPS-1 -> error.
    - Transfer with wr_count = NTAPS-1 and cfg_last = 0 -> error.
  - PEND: holds. When swap_en = 1, all NTAPS shadow words are copied to the active registers in one cycle, then -> IDLE.
  - swap_en is sampled only in PEND; swap_en in any other state has no effect.
- Timing:
  - If the last word transfers at edge N, PEND is entered at edge N.
  - swap_en high in the cycle after N -> the copy, load_done = 1 and the bank_id toggle all appear after edge N+1.
  - load_done is registered, high for exactly one cycle.
- Error handling:
  - On an error: load_err pulses one cycle, wr_count -> 0, state -> IDLE, and the active bank and bank_id are unchanged.
  - Shadow contents need not be cleared.
- Abort:
  - cfg_abort = 1 in LOAD or PEND -> IDLE and wr_count = 0, with no load_err and no load_done.
  - cfg_abort has priority over a simultaneous transfer (the word is not written) and over a simultaneous swap_en (no copy).
  - cfg_abort in IDLE blocks any transfer that cycle; state stays IDLE.
- busy is registered and equals (state != IDLE).
- Reset (rst_n = 0 at a clk edge), regardless of state:
  - state = IDLE, wr_count = 0.
  - coeff_flat = 0, bank_id = 0, load_done = 0, load_err = 0, busy = 0.
  - cfg_ready = 1 on the first cycle after reset is released.
  - Reset mid-load discards the partial set; a pending swap is lost.
- Width: no arithmetic is applied to coefficients; bits are stored and forwarded verbatim.
- wr_count never exceeds NTAPS-1.

Test Plan:
- Reset, then stream words 0x0001..0x0021 with cfg_last on the 33rd word, then pulse swap_en 3 cycles later -> cfg_ready = 0 in PEND; after the swap tap k = k+1, load_done is one pulse, bank_id = 1, busy = 0.
- Assert cfg_last on word 10 -> load_err pulses once; coeff_flat and bank_id unchanged; wr_count = 0; next full load succeeds.
- Send 33 words with cfg_last = 0 on word 33 -> load_err on that transfer; state returns to IDLE.
- Random cfg_valid gaps (50% duty) during a load of 0x8000 on all taps -> same final coeff_flat as the gapless load; no dropped or duplicated words.
- Reach PEND, then raise cfg_abort and swap_en in the same cycle -> no copy, no load_done, bank_id unchanged, busy = 0 next cycle.
- Drop rst_n at wr_count = 20 after a prior successful load -> coeff_flat = 0, wr_count = 0, cfg_ready = 1 once rst_n is high.
